// File: rtl/mod_counter_checker.sv
// -----------------------------------------------------------------------------
// mod_counter_checker
//   In-line checker placed downstream of a mod-MOD up/down counter. Every clock
//   it samples the counter controls and the counter output, compares the output
//   against the count predicted on the previous edge, and reports mismatches,
//   illegal values and legal wraps as registered one-cycle pulses. Saturating
//   error and wrap statistics are kept for debug.
//
// Ports
//   clock        in   1      single clock, all activity on posedge
//   reset        in   1      synchronous, active-high
//   load         in   1      counter load control
//   data_in      in   WIDTH  counter load value
//   upd          in   1      counter direction (1 = up, 0 = down)
//   count        in   WIDTH  counter output under check
//   mismatch     out  1      pulse: count differed from prediction
//   illegal_val  out  1      pulse: count >= MOD or load with data_in >= MOD
//   wrap         out  1      pulse: legal wrap MOD-1 -> 0 (up) or 0 -> MOD-1 (down)
//   synced       out  1      prediction valid (TRACK state)
//   exp_count    out  WIDTH  predicted count for the next sample, 0 when not synced
//   err_count    out  ERR_W  saturating count of edges with mismatch/illegal_val
//   wrap_count   out  ERR_W  saturating count of wrap events
// -----------------------------------------------------------------------------
module mod_counter_checker #(
  parameter int MOD           = 12,
  parameter int WIDTH         = 4,
  parameter int ERR_W         = 8,
  parameter int RESYNC_ON_ERR = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             upd,
  input  logic [WIDTH-1:0] count,
  output logic             mismatch,
  output logic             illegal_val,
  output logic             wrap,
  output logic             synced,
  output logic [WIDTH-1:0] exp_count,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count
);

  localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MOD - 1);
  // One extra bit so MOD == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH + 1)'(MOD);

  typedef enum logic {
    S_TRACK = 1'b0,
    S_LOST  = 1'b1
  } state_t;

  // Next value the counter should take; wrap is at MOD, not at 2**WIDTH.
  function automatic logic [WIDTH-1:0] nxt_count(
    input logic             ld,
    input logic [WIDTH-1:0] din,
    input logic             up,
    input logic [WIDTH-1:0] c
  );
    if (ld)
      return din;
    else if (up)
      return (c == MOD_M1) ? '0 : c + WIDTH'(1);
    else
      return (c == '0) ? MOD_M1 : c - WIDTH'(1);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + ERR_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic               mismatch_q, mismatch_d;
  logic               illegal_q, illegal_d;
  logic               wrap_q, wrap_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [ERR_W-1:0]   wrapc_q, wrapc_d;
  // Previous sample, used to recognise a wrap across two edges.
  logic [WIDTH-1:0]   prev_count_q, prev_count_d;
  logic               prev_load_q, prev_load_d;
  logic               prev_upd_q, prev_upd_d;
  logic               prev_vld_q, prev_vld_d;

  logic cnt_illegal;
  logic load_illegal;
  logic wrap_seen;

  always_comb begin
    cnt_illegal  = ({1'b0, count} >= MOD_W);
    load_illegal = load && ({1'b0, data_in} >= MOD_W);
    // The transition into this sample was driven by the controls of the
    // previous edge; a load there means the jump is not a wrap.
    wrap_seen    = prev_vld_q && !prev_load_q &&
                   (( prev_upd_q && (prev_count_q == MOD_M1) && (count == '0)) ||
                    (!prev_upd_q && (prev_count_q == '0)     && (count == MOD_M1)));
  end

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    mismatch_d   = 1'b0;
    illegal_d    = 1'b0;
    wrap_d       = 1'b0;
    err_d        = err_q;
    wrapc_d      = wrapc_q;
    prev_count_d = count;
    prev_load_d  = load;
    prev_upd_d   = upd;
    prev_vld_d   = 1'b1;

    case (state_q)
      S_TRACK: begin
        if (cnt_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_LOST;
          exp_d     = '0;
        end else if (count != exp_q) begin
          mismatch_d = 1'b1;
          if (RESYNC_ON_ERR != 0) begin
            exp_d = nxt_count(load, data_in, upd, count);
          end else begin
            state_d = S_LOST;
            exp_d   = '0;
          end
        end else begin
          exp_d  = nxt_count(load, data_in, upd, count);
          wrap_d = wrap_seen;
        end
      end
      default: begin
        exp_d = '0;
        if (load && !load_illegal) begin
          state_d = S_TRACK;
          exp_d   = data_in;
        end
      end
    endcase

    // An out-of-range load invalidates the prediction from any state; the
    // compare result above is still reported alongside it.
    if (load_illegal) begin
      illegal_d = 1'b1;
      state_d   = S_LOST;
      exp_d     = '0;
    end

    if (mismatch_d || illegal_d)
      err_d = sat_inc(err_q);
    if (wrap_d)
      wrapc_d = sat_inc(wrapc_q);
  end

  // Registered outputs: one clock after the sampling edge.
  always_ff @(posedge clock) begin
    prev_count_q <= prev_count_d;
    prev_load_q  <= prev_load_d;
    prev_upd_q   <= prev_upd_d;
    if (reset) begin
      state_q    <= S_TRACK;
      exp_q      <= '0;
      mismatch_q <= 1'b0;
      illegal_q  <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= '0;
      wrapc_q    <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
      illegal_q  <= illegal_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      wrapc_q    <= wrapc_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign mismatch    = mismatch_q;
  assign illegal_val = illegal_q;
  assign wrap        = wrap_q;
  assign synced      = (state_q == S_TRACK);
  assign exp_count   = exp_q;
  assign err_count   = err_q;
  assign wrap_count  = wrapc_q;

endmodule
